// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller: FSM encoding and
// the instruction-field constants the controller keys on.
package hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_IMISS  = 3'd1,
        ST_DMISS  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam logic [3:0] OP_HLT   = 4'hF;
    localparam logic [3:0] REG_ZERO = 4'h0;

    // A source only conflicts when it is actually read and is not r0.
    function automatic logic reg_conflict(input logic [3:0] dst,
                                          input logic [3:0] src,
                                          input logic       uses);
        return uses && (dst == src) && (dst != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-facing bundle of the hazard controller: decode/execute fields and
// miss handshakes in, pipeline register enables and status out.
interface hazard_ctrl_if;
    logic [3:0]  ID_SrcReg1;
    logic [3:0]  ID_SrcReg2;
    logic        ID_Uses1;
    logic        ID_Uses2;
    logic [3:0]  ID_Opcode;
    logic        ID_BranchTaken;
    logic [3:0]  EX_RegDst;
    logic        EX_RegWrite;
    logic        EX_MemToReg;
    logic        I_Miss;
    logic        I_Done;
    logic        D_Miss;
    logic        D_Done;
    logic        PC_WEN;
    logic        IF_ID_WEN;
    logic        ID_EX_WEN;
    logic        EX_MEM_WEN;
    logic        MEM_WB_WEN;
    logic        IF_ID_Flush;
    logic        ID_EX_Bubble;
    logic        Halted;
    logic [15:0] StallCount;

    modport master (
        output ID_SrcReg1, ID_SrcReg2, ID_Uses1, ID_Uses2, ID_Opcode,
               ID_BranchTaken, EX_RegDst, EX_RegWrite, EX_MemToReg,
               I_Miss, I_Done, D_Miss, D_Done,
        input  PC_WEN, IF_ID_WEN, ID_EX_WEN, EX_MEM_WEN, MEM_WB_WEN,
               IF_ID_Flush, ID_EX_Bubble, Halted, StallCount
    );

    modport slave (
        input  ID_SrcReg1, ID_SrcReg2, ID_Uses1, ID_Uses2, ID_Opcode,
               ID_BranchTaken, EX_RegDst, EX_RegWrite, EX_MemToReg,
               I_Miss, I_Done, D_Miss, D_Done,
        output PC_WEN, IF_ID_WEN, ID_EX_WEN, EX_MEM_WEN, MEM_WB_WEN,
               IF_ID_Flush, ID_EX_Bubble, Halted, StallCount
    );
endinterface

// File: rtl/hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination is read
// by the instruction in ID.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [1:0][3:0] id_src,
    input  logic [1:0]      id_uses,
    input  logic [3:0]      ex_reg_dst,
    input  logic            ex_reg_write,
    input  logic            ex_mem_to_reg,
    output logic            load_use
);

    logic [1:0] src_hit;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_hit[gi] = reg_conflict(ex_reg_dst, id_src[gi], id_uses[gi]);
    end

    assign load_use = ex_mem_to_reg && ex_reg_write && (|src_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller: miss/drain FSM, load-use stall, branch flush
// and a saturating stall-cycle counter for the five-stage core.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_e          state_q, state_d;
    logic            i_pend_q, i_pend_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;
    logic            load_use;
    logic            pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
    logic            if_id_flush, id_ex_bubble;

    hazard_detect u_detect (
        .id_src        ({bus.ID_SrcReg2, bus.ID_SrcReg1}),
        .id_uses       ({bus.ID_Uses2, bus.ID_Uses1}),
        .ex_reg_dst    (bus.EX_RegDst),
        .ex_reg_write  (bus.EX_RegWrite),
        .ex_mem_to_reg (bus.EX_MemToReg),
        .load_use      (load_use)
    );

    always_comb begin
        pc_wen       = 1'b1;
        if_id_wen    = 1'b1;
        id_ex_wen    = 1'b1;
        ex_mem_wen   = 1'b1;
        mem_wb_wen   = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_d      = state_q;
        i_pend_d     = i_pend_q;
        drain_cnt_d  = drain_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (bus.D_Miss) begin
                    {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen} = 5'b0;
                    state_d  = bus.D_Done ? ST_RUN : ST_DMISS;
                    i_pend_d = bus.I_Miss && !bus.I_Done;
                end else if (bus.I_Miss) begin
                    pc_wen       = 1'b0;
                    if_id_wen    = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = bus.I_Done ? ST_RUN : ST_IMISS;
                end else if (load_use) begin
                    // Any taken branch this cycle is dropped; it re-resolves after the stall.
                    pc_wen       = 1'b0;
                    if_id_wen    = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (bus.ID_Opcode == OP_HLT) begin
                    pc_wen      = 1'b0;
                    if_id_wen   = 1'b0;
                    state_d     = (DRAIN_CYCLES <= 1) ? ST_HALTED : ST_DRAIN;
                    drain_cnt_d = CW'(1);
                end else if (bus.ID_BranchTaken) begin
                    if_id_flush = 1'b1;
                end
            end
            ST_IMISS: begin
                if (bus.D_Miss) begin
                    {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen} = 5'b0;
                    state_d  = ST_DMISS;
                    i_pend_d = !bus.I_Done;
                end else begin
                    pc_wen       = 1'b0;
                    if_id_wen    = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (bus.I_Done) state_d = ST_RUN;
                end
            end
            ST_DMISS: begin
                {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen} = 5'b0;
                if (bus.I_Done) i_pend_d = 1'b0;
                if (bus.D_Done) begin
                    state_d  = (i_pend_q && !bus.I_Done) ? ST_IMISS : ST_RUN;
                    i_pend_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (bus.D_Miss) begin
                    {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen} = 5'b0;
                end else begin
                    // IF/ID still holds the HLT; bubble so it is not issued twice.
                    pc_wen       = 1'b0;
                    if_id_wen    = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (drain_cnt_q == CW'(DRAIN_CYCLES - 1)) state_d = ST_HALTED;
                    else drain_cnt_d = drain_cnt_q + CW'(1);
                end
            end
            ST_HALTED: begin
                {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen} = 5'b0;
            end
            default: state_d = ST_RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (!pc_wen && state_q != ST_HALTED && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            i_pend_q    <= 1'b0;
            drain_cnt_q <= '0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            i_pend_q    <= i_pend_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.PC_WEN       = pc_wen;
    assign bus.IF_ID_WEN    = if_id_wen;
    assign bus.ID_EX_WEN    = id_ex_wen;
    assign bus.EX_MEM_WEN   = ex_mem_wen;
    assign bus.MEM_WB_WEN   = mem_wb_wen;
    assign bus.IF_ID_Flush  = if_id_flush;
    assign bus.ID_EX_Bubble = id_ex_bubble;
    assign bus.Halted       = (state_q == ST_HALTED);
    assign bus.StallCount   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge and
// outputs are checked 1 ns later, each step against a hand-computed value.
module tb_hazard_ctrl;

    // Output vector: {PC, IF_ID, ID_EX, EX_MEM, MEM_WB, Flush, Bubble}
    localparam logic [6:0] O_RUN = 7'b1111100;
    localparam logic [6:0] O_STL = 7'b0011101;
    localparam logic [6:0] O_FRZ = 7'b0000000;
    localparam logic [6:0] O_BR  = 7'b1111110;
    localparam logic [6:0] O_HLT = 7'b0011100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl_if hif();

    hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        $display("check %s observed=%h expected=%h", tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {hif.PC_WEN, hif.IF_ID_WEN, hif.ID_EX_WEN, hif.EX_MEM_WEN,
               hif.MEM_WB_WEN, hif.IF_ID_Flush, hif.ID_EX_Bubble};
        chk(tag, {9'd0, obs}, {9'd0, exp});
    endtask

    task automatic idle();
        hif.ID_SrcReg1 = 4'd0;  hif.ID_SrcReg2 = 4'd0;
        hif.ID_Uses1 = 1'b0;    hif.ID_Uses2 = 1'b0;
        hif.ID_Opcode = 4'h0;   hif.ID_BranchTaken = 1'b0;
        hif.EX_RegDst = 4'd0;   hif.EX_RegWrite = 1'b0; hif.EX_MemToReg = 1'b0;
        hif.I_Miss = 1'b0;      hif.I_Done = 1'b0;
        hif.D_Miss = 1'b0;      hif.D_Done = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_in_ex(input logic [3:0] dst);
        hif.EX_RegDst = dst; hif.EX_RegWrite = 1'b1; hif.EX_MemToReg = 1'b1;
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_out("reset_outputs", O_RUN);
        chk("reset_halted", {15'd0, hif.Halted}, 16'd0);
        chk("reset_stallcnt", hif.StallCount, 16'd0);

        // Load-use on source 1, then recovery
        @(negedge clk);
        load_in_ex(4'd3); hif.ID_SrcReg1 = 4'd3; hif.ID_Uses1 = 1'b1; #1;
        chk_out("lu_src1_stall", O_STL);
        @(negedge clk); idle(); #1;
        chk_out("lu_recover", O_RUN);
        chk("lu_stallcnt", hif.StallCount, 16'd1);
        // r0 destination, and a match with the Uses bit clear: no stall
        load_in_ex(4'd0); hif.ID_SrcReg1 = 4'd0; hif.ID_Uses1 = 1'b1; #1;
        chk_out("lu_r0_nostall", O_RUN);
        @(negedge clk); idle();
        load_in_ex(4'd3); hif.ID_SrcReg2 = 4'd3; hif.ID_Uses2 = 1'b0; #1;
        chk_out("lu_nouse_nostall", O_RUN);
        hif.ID_Uses2 = 1'b1; #1;
        chk_out("lu_src2_stall", O_STL);
        hif.EX_MemToReg = 1'b0; #1;
        chk_out("lu_notload_nostall", O_RUN);
        @(negedge clk); idle(); #1;
        chk("lu_r0_stallcnt", hif.StallCount, 16'd1);

        // Branch alone flushes; with a load-use the stall wins
        hif.ID_BranchTaken = 1'b1; #1;
        chk_out("br_flush", O_BR);
        @(negedge clk); idle(); #1;
        chk_out("br_flush_oneshot", O_RUN);
        hif.ID_BranchTaken = 1'b1; load_in_ex(4'd5);
        hif.ID_SrcReg1 = 4'd5; hif.ID_Uses1 = 1'b1; #1;
        chk_out("br_with_lu", O_STL);

        // I-miss for 5 cycles, I_Done on the 5th
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            hif.I_Miss = 1'b1; hif.I_Done = (k == 5); #1;
            chk_out($sformatf("imiss_c%0d", k), O_STL);
            @(negedge clk);
        end
        idle(); #1;
        chk_out("imiss_resume", O_RUN);
        chk("imiss_stallcnt", hif.StallCount, 16'd5);

        // Plain D-miss: freeze until the cycle after D_Done
        do_reset();
        for (int t = 0; t <= 2; t++) begin
            hif.D_Miss = 1'b1; hif.D_Done = (t == 2); #1;
            chk_out($sformatf("dmiss_t%0d", t), O_FRZ);
            @(negedge clk);
        end
        idle(); #1;
        chk_out("dmiss_resume", O_RUN);

        // D-miss nested inside an I-miss
        do_reset();
        for (int t = 0; t <= 9; t++) begin
            hif.I_Miss = (t <= 8); hif.I_Done = (t == 8);
            hif.D_Miss = (t >= 2 && t <= 6); hif.D_Done = (t == 6); #1;
            if (t <= 1 || t == 7 || t == 8) chk_out($sformatf("nest_t%0d", t), O_STL);
            else if (t <= 6) chk_out($sformatf("nest_t%0d", t), O_FRZ);
            else chk_out($sformatf("nest_t%0d", t), O_RUN);
            if (t < 9) @(negedge clk);
        end
        chk("nest_stallcnt", hif.StallCount, 16'd9);

        // HLT drain
        do_reset();
        hif.ID_Opcode = 4'hF; #1;
        chk_out("hlt_t0", O_HLT);
        @(negedge clk); #1;
        chk_out("hlt_t1_drain", O_STL);
        chk("hlt_t1_halted", {15'd0, hif.Halted}, 16'd0);
        @(negedge clk); #1;
        chk("hlt_t2_halted", {15'd0, hif.Halted}, 16'd0);
        @(negedge clk); #1;
        chk("hlt_t3_halted", {15'd0, hif.Halted}, 16'd1);
        chk_out("hlt_t3_frozen", O_FRZ);
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("hlt_t5_halted", {15'd0, hif.Halted}, 16'd1);
        chk("hlt_stallcnt", hif.StallCount, 16'd3);

        // D-miss inside DRAIN delays Halted by one cycle
        do_reset();
        hif.ID_Opcode = 4'hF; #1;
        @(negedge clk); hif.D_Miss = 1'b1; #1;
        chk_out("drain_dmiss_frz", O_FRZ);
        @(negedge clk); hif.D_Miss = 1'b0; #1;
        chk_out("drain_resume", O_STL);
        @(negedge clk); #1;
        chk("drain_dmiss_t3", {15'd0, hif.Halted}, 16'd0);
        @(negedge clk); #1;
        chk("drain_dmiss_t4", {15'd0, hif.Halted}, 16'd1);

        // Async reset in the middle of a drain, away from any clock edge
        do_reset();
        hif.ID_Opcode = 4'hF; #1;
        @(negedge clk); #1;
        chk("rst_pre_stallcnt", hif.StallCount, 16'd1);
        idle(); rst = 1'b1; #1;
        chk("rst_async_stallcnt", hif.StallCount, 16'd0);
        chk_out("rst_async_outputs", O_RUN);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_no_halt", {15'd0, hif.Halted}, 16'd0);
        chk_out("rst_run_outputs", O_RUN);

        // Saturation: hold an I-miss long enough to reach the top of the counter
        do_reset();
        hif.I_Miss = 1'b1;
        repeat (65534) @(negedge clk);
        #1;
        chk("sat_fffe", hif.StallCount, 16'hFFFE);
        repeat (3) @(negedge clk);
        #1;
        chk("sat_hold", hif.StallCount, 16'hFFFF);
        hif.I_Done = 1'b1;
        @(negedge clk); idle(); #1;
        chk("sat_after_done", hif.StallCount, 16'hFFFF);
        chk_out("sat_resume", O_RUN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage 16-bit core. It drives the write-enable and bubble inputs of the IF/ID and ID/EX pipeline registers from decode-stage source registers and execute-stage destination/control fields. It also sequences instruction- and data-memory miss stalls and the HLT drain, and keeps a saturating stall-cycle counter. It sits beside the decode stage as the producer of the `WEN` consumed by the ID/EX register.

## Interface
- `DRAIN_CYCLES`, default 3: cycles after HLT enters ID until the pipeline is empty and `Halted` asserts.
- `clk`  in  1  single core clock.
- `rst`  in  1  asynchronous, active-high reset; one clock, `clk`.
- `ID_SrcReg1`, `ID_SrcReg2`  in  4 each  source register fields of the instruction in ID.
- `ID_Uses1`, `ID_Uses2`  in  1 each  the ID instruction reads that source.
- `ID_Opcode`  in  4  opcode in ID; 4'hF = HLT.
- `ID_BranchTaken`  in  1  branch/jump resolved taken in ID this cycle.
- `EX_RegDst`  in  4  destination register of the instruction in EX.
- `EX_RegWrite`, `EX_MemToReg`  in  1 each  EX instruction writes a register / is a load.
- `I_Miss`, `I_Done`  in  1 each  fetch miss level; single-cycle fill-complete pulse.
- `D_Miss`, `D_Done`  in  1 each  data-memory miss level; single-cycle fill-complete pulse.
- `PC_WEN`, `IF_ID_WEN`, `ID_EX_WEN`, `EX_MEM_WEN`, `MEM_WB_WEN`  out  1 each  pipeline register enables.
- `IF_ID_Flush`  out  1  load a NOP into IF/ID.
- `ID_EX_Bubble`  out  1  force all ID/EX control fields to 0 (RegWrite, StoreInstr, MemToReg).
- `Halted`  out  1  pipeline drained after HLT.
- `StallCount`  out  16  saturating count of cycles with `PC_WEN` = 0 and `Halted` = 0.

## Operation
- FSM states: RUN, IMISS, DMISS, DRAIN, HALTED. Reset state is RUN.
- Load-use condition: `EX_MemToReg & EX_RegWrite & EX_RegDst != 0`, and the EX destination matches an ID source with its `Uses` bit set. Register 0 never creates a hazard.
- Priority, highest first:
  1. DMISS, or `D_Miss` while in RUN: all enables 0, no bubble. The whole pipeline freezes.
  2. IMISS, or `I_Miss` while in RUN: `PC_WEN` = `IF_ID_WEN` = 0, `ID_EX_Bubble` = 1, downstream enables 1.
  3. Load-use: `PC_WEN` = `IF_ID_WEN` = 0, `ID_EX_Bubble` = 1.
  4. `ID_BranchTaken`: `IF_ID_Flush` = 1, all enables 1.
- Transitions:
  - RUN→DMISS on `D_Miss`; DMISS→RUN on `D_Done`.
  - RUN→IMISS on `I_Miss`, but only if `D_Miss` = 0. IMISS→RUN on `I_Done`.
  - `D_Miss` during IMISS moves to DMISS. The pending I-fill stays flagged and returns to IMISS after `D_Done` unless `I_Done` was seen meanwhile.
  - HLT in ID while in RUN with no stall → DRAIN. `PC_WEN` and `IF_ID_WEN` are 0 from that cycle; the HLT itself advances into ID/EX.
  - DRAIN counts `DRAIN_CYCLES` cycles and then enters HALTED. A D-miss in DRAIN freezes the counter.
  - HALTED is terminal until `rst`. All enables are 0 and `Halted` = 1.
- A taken branch coincident with a load-use stall is ignored this cycle; it re-resolves after the stall.
- `StallCount` increments by 1 per stalled cycle and saturates at 16'hFFFF with no wrap.

## Timing
- All enable, flush and bubble outputs are combinational from the current state and inputs. They take effect at the same edge as the register they gate.
- Transitions are registered, with one-cycle latency from `Miss` or `Done` to the state change.
- Miss handshake: `Miss` is held high until `Done`. In the `Done` cycle, stall outputs are still asserted. Normal flow resumes the following cycle.
- A load-use stall lasts exactly one cycle, because the bubble clears EX on the next edge.
- Reset values:
  - State is RUN and the drain counter is 0.
  - `StallCount` = 0 and `Halted` = 0.
  - With idle inputs, all enables are 1 and flush and bubble are 0.
- Asserting `rst` mid-miss or mid-drain returns to RUN immediately; the async clear holds regardless of `clk`.

## Structure
- A shared core package holds the state encoding (3-bit), the HLT opcode constant 4'hF, and the zero-register constant.
- One sub-module, `hazard_detect`: the pure combinational load-use comparator. The FSM, drain counter and stall counter stay in the top level.

## Test plan
- Load-use hazard:
  - Stimulus: EX has load to r3 (`EX_MemToReg` = 1, `EX_RegWrite` = 1); ID reads r3 via `Uses1`.
  - Response: for one cycle `PC_WEN` = 0, `IF_ID_WEN` = 0, `ID_EX_Bubble` = 1. Next cycle with no hazard, all enables are 1 and `StallCount` = 1.
  - Repeat with r0 as the destination: no stall.
- I-miss: `I_Miss` high 5 cycles, `I_Done` on the 5th.
  - Response: PC and IF/ID frozen and bubbles issued for 5 cycles; RUN on the 6th; `StallCount` = 5.
- D-miss during I-miss: `I_Miss` at t0, `D_Miss` at t2, `D_Done` at t6, `I_Done` at t8.
  - Response: all enables 0 from t2 to t6; IMISS resumes at t7; RUN at t9.
- Branch with load-use: `ID_BranchTaken` with no hazard gives `IF_ID_Flush` = 1 for one cycle. Coincident with load-use, flush is 0 and the stall wins.
- HLT drain: HLT in ID at t0.
  - Response: `PC_WEN` = 0 from t0; `Halted` = 1 at t0+3 and stays there.
  - `rst` pulse at t0+1 instead: back to RUN, `Halted` = 0, `StallCount` = 0.
- Saturation: force `StallCount` to 16'hFFFE and stall 3 cycles → value holds at 16'hFFFF.
